// File: rtl/keypad_debounce.sv
// Debounces a 3x3 scanned keypad: folds each three-row sweep into one frame
// result, qualifies presses/releases over STABLE_FRAMES frames, pulses key_valid once per press.
module keypad_debounce #(
  parameter int STABLE_FRAMES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_loc,
  output logic       key_held
);

  typedef enum logic [1:0] {ACC_NONE, ACC_SINGLE, ACC_MULTI} acc_t;
  typedef enum logic [1:0] {IDLE, PRESS_CAND, PRESSED, REL_CAND} state_t;

  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // cell_hit[gi] marks key gi+1 (row gi/3, column gi%3) sensed this cycle
  logic [8:0] cell_hit;
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_cell
      assign cell_hit[gi] = row[gi / 3] & col[gi % 3];
    end
  endgenerate

  logic       row_onehot;
  logic [1:0] col_ones;
  logic       frame_end;
  acc_t       cyc_kind;
  logic [3:0] cyc_loc;

  assign row_onehot = (row == 3'b001) || (row == 3'b010) || (row == 3'b100);
  assign col_ones   = 2'(col[0]) + 2'(col[1]) + 2'(col[2]);
  assign frame_end  = (row == 3'b100);

  always_comb begin
    cyc_kind = ACC_NONE;
    cyc_loc  = 4'd0;
    if (row_onehot && (col_ones != 2'd0)) begin
      if (col_ones == 2'd1) begin
        cyc_kind = ACC_SINGLE;
      end else begin
        cyc_kind = ACC_MULTI;
      end
    end
    for (int i = 0; i < 9; i++) begin
      if (cell_hit[i]) begin
        cyc_loc = 4'(i + 1);
      end
    end
  end

  // Frame accumulator: merge this cycle's contribution into the running frame
  acc_t       acc_kind_reg, acc_kind_next;
  logic [3:0] acc_loc_reg, acc_loc_next;
  acc_t       merged_kind;
  logic [3:0] merged_loc;

  always_comb begin
    merged_kind = acc_kind_reg;
    merged_loc  = acc_loc_reg;
    if ((cyc_kind == ACC_MULTI) || (acc_kind_reg == ACC_MULTI)) begin
      merged_kind = ACC_MULTI;
    end else if (cyc_kind == ACC_SINGLE) begin
      if (acc_kind_reg == ACC_NONE) begin
        merged_kind = ACC_SINGLE;
        merged_loc  = cyc_loc;
      end else if (acc_loc_reg != cyc_loc) begin
        merged_kind = ACC_MULTI;
      end
    end
  end

  always_comb begin
    acc_kind_next = merged_kind;
    acc_loc_next  = merged_loc;
    if (frame_end) begin
      acc_kind_next = ACC_NONE;
      acc_loc_next  = 4'd0;
    end
  end

  // Debounce state machine, only advances on frame-end cycles
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       cand_reg, cand_next;
  logic             valid_reg, valid_next;
  logic [3:0]       loc_reg, loc_next;
  logic             held_reg, held_next;
  logic             frame_single, frame_none;
  logic             do_accept, do_release;

  assign cnt_inc      = cnt_reg + CNT_ONE;
  assign frame_single = (merged_kind == ACC_SINGLE);
  assign frame_none   = (merged_kind == ACC_NONE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    valid_next = 1'b0;
    loc_next   = loc_reg;
    held_next  = held_reg;
    do_accept  = 1'b0;
    do_release = 1'b0;
    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (frame_single) begin
            cand_next = merged_loc;
            cnt_next  = CNT_ONE;
            if (CNT_ONE == CNT_TARGET) begin
              do_accept = 1'b1;
            end else begin
              state_next = PRESS_CAND;
            end
          end
        end
        PRESS_CAND: begin
          if (frame_single) begin
            if (merged_loc == cand_reg) begin
              cnt_next  = cnt_inc;
              do_accept = (cnt_inc == CNT_TARGET);
            end else begin
              cand_next = merged_loc;
              cnt_next  = CNT_ONE;
              do_accept = (CNT_ONE == CNT_TARGET);
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        PRESSED: begin
          if (frame_none) begin
            cnt_next = CNT_ONE;
            if (CNT_ONE == CNT_TARGET) begin
              do_release = 1'b1;
            end else begin
              state_next = REL_CAND;
            end
          end
        end
        REL_CAND: begin
          if (frame_none) begin
            cnt_next   = cnt_inc;
            do_release = (cnt_inc == CNT_TARGET);
          end else begin
            state_next = PRESSED;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
    if (do_accept) begin
      state_next = PRESSED;
      cnt_next   = '0;
      valid_next = 1'b1;
      loc_next   = merged_loc;
      held_next  = 1'b1;
    end
    if (do_release) begin
      state_next = IDLE;
      cnt_next   = '0;
      held_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_kind_reg <= ACC_NONE;
      acc_loc_reg  <= 4'd0;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      cand_reg     <= 4'd0;
      valid_reg    <= 1'b0;
      loc_reg      <= 4'd0;
      held_reg     <= 1'b0;
    end else begin
      acc_kind_reg <= acc_kind_next;
      acc_loc_reg  <= acc_loc_next;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      cand_reg     <= cand_next;
      valid_reg    <= valid_next;
      loc_reg      <= loc_next;
      held_reg     <= held_next;
    end
  end

  assign key_valid = valid_reg;
  assign key_loc   = loc_reg;
  assign key_held  = held_reg;

endmodule
